ir_tx_periph: RTL
=================

IR_TX_PERIPH -- requirements
Module: ir_tx_periph

Interface
REQ-001 The module SHALL expose parameter TX_ADDR, default 5'd30, memory-mapped address of the transmit data register (write-only).
REQ-002 The module SHALL expose parameter STAT_ADDR, default 5'd31, memory-mapped address of the status register (read-only).
REQ-003 The module SHALL expose parameter UNIT_CYCLES, default 8, clock cycles per protocol time unit (>=2).
REQ-004 The module SHALL expose parameter CARRIER_HALF, default 2, clock cycles per carrier half-period (>=1).
REQ-005 Ports SHALL be:
  clk  input  1  single system clock, all state on rising edge
  reset  input  1  asynchronous, active-high reset
  MemWrite  input  1  CPU store strobe
  dir  input  5  CPU data address (ALU result [4:0])
  WD  input  32  CPU store data; only [7:0] used
  ReadData  input  32  read data from RAM/upstream peripheral
  ReadDataOut  output  32  read data returned to CPU
  ir_out  output  1  modulated IR LED drive
  busy  output  1  frame in progress

Function
REQ-006 Read mux SHALL be combinational: ReadDataOut = {31'b0, busy} when dir==STAT_ADDR, else ReadData unchanged.
REQ-007 A write SHALL be accepted at a rising clk edge iff MemWrite=1, dir==TX_ADDR, state==IDLE; WD[7:0] latched into shift register.
REQ-008 Writes to TX_ADDR while busy=1 SHALL be ignored with no side effects; writes to any other address SHALL be ignored.
REQ-009 FSM states SHALL be IDLE, START_MARK, START_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
REQ-010 Durations in units: START_MARK 8, START_SPACE 4, BIT_MARK 1, BIT_SPACE 1 for bit=0 and 3 for bit=1, STOP_MARK 1; one unit = UNIT_CYCLES cycles.
REQ-011 Transitions: accepted write -> START_MARK; START_MARK -> START_SPACE; START_SPACE -> BIT_MARK; BIT_MARK -> BIT_SPACE; BIT_SPACE -> BIT_MARK while bits remain, else STOP_MARK; STOP_MARK -> IDLE.
REQ-012 Data bits SHALL be sent LSB first, 8 bits per frame; a 3-bit counter tracks bit index and shall not wrap into a ninth bit.
REQ-013 busy SHALL be registered, =1 from the accepting edge through the last STOP_MARK cycle, =0 in IDLE.
REQ-014 In mark states ir_out SHALL carry a carrier starting high on each mark's first cycle, toggling every CARRIER_HALF cycles; in space states and IDLE ir_out SHALL be 0.
REQ-015 ir_out SHALL be registered (glitch-free); first high cycle is the cycle immediately after the accepting edge.
REQ-016 Frame length SHALL be UNIT_CYCLES*(8+4+Σ(2 or 4 per bit)+1) cycles: 232 for 0x00, 360 for 0xFF at defaults.
REQ-017 A write accepted in the first IDLE cycle after STOP_MARK SHALL start a new frame with no extra gap.
REQ-018 Unit and carrier counters SHALL restart at 0 on every state change.

Reset
REQ-019 reset=1 SHALL immediately force state IDLE, busy=0, ir_out=0, shift register, bit and cycle counters to 0, regardless of clk.
REQ-020 Reset asserted mid-frame SHALL abort the frame; no resume after release; first accepted write after release starts a fresh frame.
REQ-021 ReadDataOut SHALL remain combinational during reset (status reads 0).

Verification
REQ-022 Reset, write 0x00 to 30 -> busy=1 next cycle, ir_out 1,1,0,0,... for 64 cycles, 0 for 32, then 8x(8-cycle mark, 8-cycle space), 8-cycle stop mark, busy=0 at cycle 232.
REQ-023 Write 0xA5 -> bit spaces in order 24,8,24,8,8,24,8,24 cycles; total 296 cycles.
REQ-024 Write 0x3C at cycle 10 of a frame -> ignored, frame completes with original data, busy timing unchanged.
REQ-025 Read dir=31 during frame -> ReadDataOut=0x00000001; dir=31 idle -> 0x0; dir=5, ReadData=0xDEADBEEF -> 0xDEADBEEF.
REQ-026 Assert reset at cycle 100 between edges -> ir_out=0, busy=0 same cycle; after release write 0xFF -> full 360-cycle frame.
REQ-027 Back-to-back: write 0x01 then write 0x02 in first idle cycle -> second frame's first mark begins next cycle, no gap.

Source files
------------

// File: rtl/ir_tx_periph.sv
// Memory-mapped IR transmitter: a byte written to TX_ADDR is sent as a pulse-distance frame on a modulated carrier.
// Status register at STAT_ADDR returns the busy flag; all other reads pass ReadData through.
module ir_tx_periph #(
  parameter logic [4:0] TX_ADDR      = 5'd30,
  parameter logic [4:0] STAT_ADDR    = 5'd31,
  parameter int         UNIT_CYCLES  = 8,
  parameter int         CARRIER_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [4:0]  dir,
  input  logic [31:0] WD,
  input  logic [31:0] ReadData,
  output logic [31:0] ReadDataOut,
  output logic        ir_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START_MARK, START_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  localparam int CW  = $clog2(8 * UNIT_CYCLES);
  localparam int CCW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  // Terminal counts for 8, 4, 3 and 1 time units
  localparam logic [CW-1:0]  LAST8   = CW'(8 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0]  LAST4   = CW'(4 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0]  LAST3   = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0]  LAST1   = CW'(UNIT_CYCLES - 1);
  localparam logic [CCW-1:0] CARLAST = CCW'(CARRIER_HALF - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n, last_cnt;
  logic [CCW-1:0] car, car_n;
  logic           phase, phase_n;
  logic [7:0]     shreg, shreg_n;
  logic [2:0]     bit_idx, bit_n;
  logic           mark_n, done;

  logic unused_wd;
  assign unused_wd = ^WD[31:8];

  assign ReadDataOut = (dir == STAT_ADDR) ? {31'b0, busy} : ReadData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      car     <= '0;
      phase   <= 1'b0;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
      ir_out  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      car     <= car_n;
      phase   <= phase_n;
      shreg   <= shreg_n;
      bit_idx <= bit_n;
      ir_out  <= mark_n & phase_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    car_n    = car;
    phase_n  = phase;
    shreg_n  = shreg;
    bit_n    = bit_idx;
    last_cnt = LAST1;

    case (state)
      START_MARK:  last_cnt = LAST8;
      START_SPACE: last_cnt = LAST4;
      BIT_SPACE:   last_cnt = shreg[0] ? LAST3 : LAST1;
      default:     last_cnt = LAST1;
    endcase
    done = (cnt == last_cnt);

    case (state)
      IDLE: begin
        if (MemWrite && (dir == TX_ADDR)) begin
          state_n = START_MARK;
          shreg_n = WD[7:0];
          bit_n   = 3'd0;
        end
      end
      START_MARK:  if (done) state_n = START_SPACE;
      START_SPACE: if (done) state_n = BIT_MARK;
      BIT_MARK:    if (done) state_n = BIT_SPACE;
      BIT_SPACE: begin
        if (done) begin
          // The bit index saturates at 7 so a ninth bit can never be sent
          if (bit_idx == 3'd7) begin
            state_n = STOP_MARK;
          end else begin
            state_n = BIT_MARK;
            bit_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP_MARK:   if (done) state_n = IDLE;
      default:     state_n = IDLE;
    endcase

    // Every state change restarts the unit timer and the carrier high
    if (state_n != state) begin
      cnt_n   = '0;
      car_n   = '0;
      phase_n = 1'b1;
    end else if (state != IDLE) begin
      cnt_n = cnt + 1'b1;
      if (car == CARLAST) begin
        car_n   = '0;
        phase_n = ~phase;
      end else begin
        car_n = car + 1'b1;
      end
    end

    mark_n = (state_n == START_MARK) || (state_n == BIT_MARK) || (state_n == STOP_MARK);
  end

endmodule
